// File: rtl/config_reg_arbiter.sv
// Round-robin arbitrated write port into a bank of configuration registers.
// A winner is captured into a pending slot at one edge and committed at the next edge.
module config_reg_arbiter #(
    parameter int              NREQ  = 4,
    parameter int              NREGS = 8,
    parameter int              AW    = 3,
    parameter int              DW    = 32,
    parameter logic [DW-1:0]   INIT  = '0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ_VALID,
    input  logic [NREQ*AW-1:0]  REQ_ADDR,
    input  logic [NREQ*DW-1:0]  REQ_DATA,
    output logic [NREQ-1:0]     REQ_ACK,
    input  logic [AW-1:0]       RD_ADDR,
    output logic [DW-1:0]       RD_DATA,
    output logic [NREGS*DW-1:0] CFG_OUT,
    output logic                BUSY,
    output logic                ERR
);

    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    logic [NREGS-1:0][DW-1:0] bank_q, bank_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [NREQ-1:0]          ack_q, ack_d;
    logic                     busy_q, busy_d;
    logic [AW-1:0]            pend_addr_q, pend_addr_d;
    logic [DW-1:0]            pend_data_q, pend_data_d;
    logic                     err_q, err_d;

    logic [NREQ-1:0] eligible;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   rr_idx;
    int              rr_sum;
    logic            pend_in_range;

    // Handshake: a requester holds REQ_VALID with stable addr/data until it sees
    // REQ_ACK for one cycle; during that ACK cycle it is not eligible again.
    always_comb begin
        eligible  = REQ_VALID & ~ack_q;
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = 0;
        rr_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            rr_sum = int'(ptr_q) + i;
            if (rr_sum >= NREQ) begin
                rr_sum = rr_sum - NREQ;
            end
            rr_idx = PW'(rr_sum);
            if (!win_found && eligible[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    always_comb begin
        pend_in_range = ({1'b0, pend_addr_q} < NREGS_W);
        bank_d        = bank_q;
        err_d         = err_q;
        ack_d         = '0;
        busy_d        = win_found;
        ptr_d         = ptr_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;

        // Commit stage: out-of-range writes are dropped and flagged.
        if (busy_q) begin
            if (pend_in_range) begin
                bank_d[pend_addr_q] = pend_data_q;
            end else begin
                err_d = 1'b1;
            end
        end

        if (win_found) begin
            ack_d[win_idx] = 1'b1;
            pend_addr_d    = REQ_ADDR[win_idx*AW +: AW];
            pend_data_d    = REQ_DATA[win_idx*DW +: DW];
            ptr_d          = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bank_q      <= {NREGS{INIT}};
            ptr_q       <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            err_q       <= err_d;
        end
    end

    assign REQ_ACK = ack_q;
    assign BUSY    = busy_q;
    assign ERR     = err_q;
    assign CFG_OUT = bank_q;
    assign RD_DATA = ({1'b0, RD_ADDR} < NREGS_W) ? bank_q[RD_ADDR] : '0;

endmodule
